// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - master identifiers and reset grant value for the port A arbiter
package ram_arb_pkg;

    // One bit is enough to name either master.
    typedef logic master_t;

    localparam master_t M0 = 1'b0;
    localparam master_t M1 = 1'b1;

    // last_q resets to master 1 so the first round-robin tie goes to master 0.
    localparam master_t GRANT_RST = M1;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - winner select; RAM_ARB_RR_EN selects round-robin tie-break, else fixed priority
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    input  logic lock,
    output logic grant,
    output logic winner
);

    logic tie_winner;

`ifdef RAM_ARB_RR_EN
    // Round-robin: on a tie the master that did not win last time goes next.
    always_comb begin
        tie_winner = (last == M0) ? M1 : M0;
    end
`else
    // Fixed priority: master 0 takes every tie; the grant history is not consulted.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        tie_winner = M0;
    end
`endif

    // A held lock always favours master 1; a lone requester always wins.
    always_comb begin
        grant  = valid0 | valid1;
        winner = M0;
        if (valid0 && valid1) begin
            winner = lock ? M1 : tie_winner;
        end else if (valid1) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/ram_arb_2m.sv
// rtl/ram_arb_2m.sv - two-master arbiter for RAM port A (RAM_ARB_RR_EN enables round-robin ties)
module ram_arb_2m
    import ram_arb_pkg::*;
#(
    parameter int DEPTH     = 2048,
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int BE_BITS   = WIDTH / 8
) (
    input  logic                 clock,
    input  logic                 reset_n,

    input  logic                 m0_cmd_valid,
    output logic                 m0_cmd_ready,
    input  logic                 m0_cmd_write,
    input  logic [ADDR_BITS-1:0] m0_cmd_addr,
    input  logic [BE_BITS-1:0]   m0_cmd_be,
    input  logic [WIDTH-1:0]     m0_cmd_wdata,
    output logic                 m0_rsp_valid,
    output logic [WIDTH-1:0]     m0_rsp_rdata,

    input  logic                 m1_cmd_valid,
    output logic                 m1_cmd_ready,
    input  logic                 m1_cmd_write,
    input  logic [ADDR_BITS-1:0] m1_cmd_addr,
    input  logic [BE_BITS-1:0]   m1_cmd_be,
    input  logic [WIDTH-1:0]     m1_cmd_wdata,
    input  logic                 m1_cmd_lock,
    output logic                 m1_rsp_valid,
    output logic [WIDTH-1:0]     m1_rsp_rdata,

    output logic [ADDR_BITS-1:0] ram_address_a,
    output logic                 ram_wren_a,
    output logic [BE_BITS-1:0]   ram_byteena_a,
    output logic [WIDTH-1:0]     ram_data_a,
    input  logic [WIDTH-1:0]     ram_q_a
);

    master_t    last_q;
    logic       lock_q;
    logic [1:0] rsp_pend_q;

    logic       any_valid;
    logic       winner;
    logic       grant_en;
    logic       grant0;
    logic       grant1;

    ram_arb_pick u_pick (
        .valid0 (m0_cmd_valid),
        .valid1 (m1_cmd_valid),
        .last   (last_q),
        .lock   (lock_q),
        .grant  (any_valid),
        .winner (winner)
    );

    // Nothing is accepted while reset is held, which also keeps ram_wren_a low.
    always_comb begin
        grant_en     = any_valid & reset_n;
        grant0       = grant_en & (winner == M0);
        grant1       = grant_en & (winner == M1);
        m0_cmd_ready = grant0;
        m1_cmd_ready = grant1;
    end

    // Steer the granted command onto port A; master 0 fields sit there when idle.
    always_comb begin
        ram_address_a = m0_cmd_addr;
        ram_data_a    = m0_cmd_wdata;
        ram_wren_a    = grant0 & m0_cmd_write;
        ram_byteena_a = m0_cmd_write ? m0_cmd_be : '1;
        if (grant1) begin
            ram_address_a = m1_cmd_addr;
            ram_data_a    = m1_cmd_wdata;
            ram_wren_a    = m1_cmd_write;
            ram_byteena_a = m1_cmd_write ? m1_cmd_be : '1;
        end
    end

    // Read data comes straight from the RAM; the pending flag says whose it is.
    always_comb begin
        m0_rsp_valid = rsp_pend_q[0];
        m1_rsp_valid = rsp_pend_q[1];
        m0_rsp_rdata = ram_q_a;
        m1_rsp_rdata = ram_q_a;
    end

    // Grant history, master 1 lock and the one-cycle read pending flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= GRANT_RST;
            lock_q     <= 1'b0;
            rsp_pend_q <= 2'b00;
        end else begin
            if (grant_en) begin
                last_q <= winner;
            end
            if (grant1) begin
                lock_q <= m1_cmd_lock;
            end else if (lock_q && !m1_cmd_valid) begin
                lock_q <= 1'b0;
            end
            rsp_pend_q <= {grant1 & ~m1_cmd_write, grant0 & ~m0_cmd_write};
        end
    end

endmodule

// File: tb/tb_ram_arb_2m.sv
// tb/tb_ram_arb_2m.sv - scoreboard bench for ram_arb_2m with a behavioural RAM and reference model
module tb_ram_arb_2m;

    localparam int DEPTH = 2048;
    localparam int WIDTH = 32;
    localparam int AB    = 11;
    localparam int BB    = 4;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;

    logic            v0 = 0, w0 = 0;
    logic [AB-1:0]   a0 = '0;
    logic [BB-1:0]   be0 = '0;
    logic [WIDTH-1:0] d0 = '0;
    logic            v1 = 0, w1 = 0, lk1 = 0;
    logic [AB-1:0]   a1 = '0;
    logic [BB-1:0]   be1 = '0;
    logic [WIDTH-1:0] d1 = '0;

    logic            m0_cmd_ready, m1_cmd_ready;
    logic            m0_rsp_valid, m1_rsp_valid;
    logic [WIDTH-1:0] m0_rsp_rdata, m1_rsp_rdata;
    logic [AB-1:0]   ram_address_a;
    logic            ram_wren_a;
    logic [BB-1:0]   ram_byteena_a;
    logic [WIDTH-1:0] ram_data_a;
    logic [WIDTH-1:0] ram_q_a = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ram_arb_2m #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .m0_cmd_valid  (v0),
        .m0_cmd_ready  (m0_cmd_ready),
        .m0_cmd_write  (w0),
        .m0_cmd_addr   (a0),
        .m0_cmd_be     (be0),
        .m0_cmd_wdata  (d0),
        .m0_rsp_valid  (m0_rsp_valid),
        .m0_rsp_rdata  (m0_rsp_rdata),
        .m1_cmd_valid  (v1),
        .m1_cmd_ready  (m1_cmd_ready),
        .m1_cmd_write  (w1),
        .m1_cmd_addr   (a1),
        .m1_cmd_be     (be1),
        .m1_cmd_wdata  (d1),
        .m1_cmd_lock   (lk1),
        .m1_rsp_valid  (m1_rsp_valid),
        .m1_rsp_rdata  (m1_rsp_rdata),
        .ram_address_a (ram_address_a),
        .ram_wren_a    (ram_wren_a),
        .ram_byteena_a (ram_byteena_a),
        .ram_data_a    (ram_data_a),
        .ram_q_a       (ram_q_a)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] init_word(int i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural RAM port A: byte-enabled write, registered read (old data on same-edge collision).
    logic [WIDTH-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    always @(posedge clock) begin
        if (ram_wren_a)
            for (int b = 0; b < BB; b++)
                if (ram_byteena_a[b]) mem[ram_address_a][8*b +: 8] <= ram_data_a[8*b +: 8];
        ram_q_a <= mem[ram_address_a];
    end

    // Reference model: memory contents seen through completed writes, plus arbitration rules.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    logic model_last = 1'b1;
    logic model_lock = 1'b0;
    logic g0_prev = 0, g1_prev = 0;

    typedef struct {
        int               due;
        logic             m;
        logic [WIDTH-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic pick_master();
        if (v0 && v1) begin
            if (model_lock) return 1'b1;
`ifdef RAM_ARB_RR_EN
            return !model_last;
`else
            return 1'b0;
`endif
        end
        return v1;
    endfunction

    // One bus cycle: inputs already driven; check grant at the falling edge, then advance.
    task automatic step();
        logic wm, g0, g1, wr;
        logic [AB-1:0] ad;
        logic [BB-1:0] be;
        logic [WIDTH-1:0] wd;
        @(negedge clock);
        wm = pick_master();
        g0 = (v0 || v1) && !wm;
        g1 = (v0 || v1) && wm;
        chk("m0_cmd_ready", m0_cmd_ready, g0);
        chk("m1_cmd_ready", m1_cmd_ready, g1);
        if (g0 || g1) begin
            wr = wm ? w1 : w0;
            ad = wm ? a1 : a0;
            be = wm ? be1 : be0;
            wd = wm ? d1 : d0;
            chk("ram_address_a", ram_address_a, ad);
            chk("ram_wren_a", ram_wren_a, wr);
            chk("ram_byteena_a", ram_byteena_a, wr ? be : 4'hF);
            if (wr) begin
                for (int b = 0; b < BB; b++)
                    if (be[b]) ref_mem[ad][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_q.push_back('{due: cyc + 1, m: wm, data: ref_mem[ad]});
            end
            model_last = wm;
        end else begin
            chk("ram_wren_idle", ram_wren_a, 0);
        end
        if (g1) model_lock = lk1;
        else if (!v1) model_lock = 1'b0;
        g0_prev = g0;
        g1_prev = g1;
        @(posedge clock);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic w, input int a, input logic [3:0] be,
                          input logic [31:0] d);
        v0 = v; w0 = w; a0 = AB'(a); be0 = be; d0 = d;
    endtask

    task automatic set_m1(input logic v, input logic w, input int a, input logic [3:0] be,
                          input logic [31:0] d, input logic lk);
        v1 = v; w1 = w; a1 = AB'(a); be1 = be; d1 = d; lk1 = lk;
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_last = 1'b1;
        model_lock = 1'b0;
        g0_prev = 0;
        g1_prev = 0;
    endtask

    // Response monitor: any response due this cycle must appear, and nothing else may.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk(e.m ? "m1_rsp_valid" : "m0_rsp_valid", e.m ? m1_rsp_valid : m0_rsp_valid, 1);
                chk("other_rsp_valid", e.m ? m0_rsp_valid : m1_rsp_valid, 0);
                chk("rsp_rdata", e.m ? m1_rsp_rdata : m0_rsp_rdata, e.data);
            end else begin
                chk("no_rsp", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
            end
        end
    end

    initial begin
        // Reset state with a write request pending: nothing may reach the RAM.
        set_m0(1, 1, 5, 4'hF, 32'hDEAD_BEEF);
        #12;
        chk("reset_wren", ram_wren_a, 0);
        chk("reset_ready", {m1_cmd_ready, m0_cmd_ready}, 0);
        chk("reset_rsp", {m1_rsp_valid, m0_rsp_valid}, 0);
        set_m0(0, 0, 0, 0, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Lone m0 read.
        set_m0(1, 0, 'h010, 0, 0);
        step();
        set_m0(0, 0, 0, 0, 0);
        step();

        // m1 full write, partial write, read back.
        set_m1(1, 1, 'h020, 4'hF, 32'h1122_3344, 0);
        step();
        set_m1(1, 1, 'h020, 4'b0011, 32'hAABB_CCDD, 0);
        step();
        set_m1(1, 0, 'h020, 0, 0, 0);
        step();
        set_m1(0, 0, 0, 0, 0, 0);
        step();

        // Continuous tie of reads.
        set_m0(1, 0, 'h030, 0, 0);
        set_m1(1, 0, 'h040, 0, 0, 0);
        for (int i = 0; i < 6; i++) step();
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        step();

        // Lock chain: m1 alone with lock, then m1 keeps grant against m0.
        set_m1(1, 0, 'h050, 0, 0, 1);
        step();
        set_m0(1, 0, 'h060, 0, 0);
        set_m1(1, 0, 'h051, 0, 0, 1);
        step();
        set_m1(1, 0, 'h052, 0, 0, 0);
        step();
        set_m1(0, 0, 0, 0, 0, 0);
        step();
        set_m0(0, 0, 0, 0, 0);
        step();

        // Lock released by m1 dropping valid.
        set_m1(1, 1, 'h070, 4'hF, 32'h0BAD_F00D, 1);
        step();
        set_m1(0, 0, 0, 0, 0, 0);
        set_m0(1, 0, 'h070, 0, 0);
        step();
        set_m1(1, 0, 'h071, 0, 0, 0);
        step();
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        step();

        // Reset pulse while an m0 read is pending.
        set_m0(1, 0, 'h010, 0, 0);
        step();
        set_m0(1, 1, 'h011, 4'hF, 32'h1234_5678);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("pulse_wren", ram_wren_a, 0);
        chk("pulse_ready", {m1_cmd_ready, m0_cmd_ready}, 0);
        chk("pulse_rsp", {m1_rsp_valid, m0_rsp_valid}, 0);
        #1 reset_n = 1'b1;
        set_m0(1, 0, 'h080, 0, 0);
        set_m1(1, 0, 'h081, 0, 0, 0);
        step();
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        step();

        // Randomised traffic; a stalled command is held unchanged.
        for (int i = 0; i < 2000; i++) begin
            if (!(v0 && !g0_prev))
                set_m0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 15), 4'($urandom), $urandom);
            if (!(v1 && !g1_prev))
                set_m1($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 15), 4'($urandom), $urandom,
                       $urandom_range(0, 3) == 0);
            step();
        end

        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arb_2m.md
# ram_arb_2m

Two-master arbiter for the read/write port A of the byte-enabled dual-port RAM. Accepts valid/ready command streams from master 0 (instruction fetch) and master 1 (data load/store), grants one per cycle, drives RAM port A, and routes the one-cycle-latency read data back to the issuing master. RAM read-only port B is not touched by this block.

## Interface
- DEPTH, 2048, RAM depth in words
- WIDTH, 32, word width in bits; multiple of 8
- ADDR_BITS (derived), $clog2(DEPTH)
- BE_BITS (derived), WIDTH/8
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- mN_cmd_valid  in  1  command present (N = 0, 1)
- mN_cmd_ready  out  1  command accepted this cycle
- mN_cmd_write  in  1  1 = write, 0 = read
- mN_cmd_addr  in  ADDR_BITS  word address
- mN_cmd_be  in  BE_BITS  byte enables (writes only)
- mN_cmd_wdata  in  WIDTH  write data
- mN_rsp_valid  out  1  read data valid
- mN_rsp_rdata  out  WIDTH  read data
- m1_cmd_lock  in  1  master 1 keeps grant after this command
- ram_address_a  out  ADDR_BITS  RAM port A address
- ram_wren_a  out  1  RAM port A write enable
- ram_byteena_a  out  BE_BITS  RAM port A byte enables
- ram_data_a  out  WIDTH  RAM port A write data
- ram_q_a  in  WIDTH  RAM port A registered read data

## Operation
- Grant computed combinationally each cycle; exactly one of mN_cmd_ready high when any valid, none otherwise.
- Only one master valid: it is granted.
- Both valid: lock_q set -> master 1; else priority rule (see Configuration).
- Granted command drives ram_* directly; ram_wren_a = granted & write; ram_byteena_a = mN_cmd_be for writes, all-ones for reads.
- No grant: ram_wren_a = 0, ram_address_a/data_a = master 0 fields (don't care).
- State: last_q (last granted master), lock_q, rsp_pend_q[1:0] (per-master read issued last cycle).
- lock_q set when master 1 accepted with m1_cmd_lock=1; cleared when master 1 accepted with lock=0, or m1_cmd_valid low in any cycle while lock_q=1.
- Writes complete on acceptance; no response. Reads produce exactly one mN_rsp_valid pulse.
- mN_rsp_rdata = ram_q_a (unregistered passthrough), valid only when mN_rsp_valid.
- Responses cannot be back-pressured.
- Reset values: last_q = 1 (master 0 wins first tie), lock_q = 0, rsp_pend_q = 0; hence m0/m1_rsp_valid = 0, ram_wren_a = 0 while reset_n low.

## Timing
- Command accepted in cycle N (valid & ready); RAM samples at end of N.
- Read: mN_rsp_valid high in cycle N+1, rdata = ram_q_a; latency 1.
- Back-to-back reads from alternating masters: one accept per cycle; responses arrive in issue order, one per cycle.
- Read-after-write same address, consecutive cycles: read returns new data. Same-cycle collision impossible (single grant).
- Master must hold cmd fields stable while valid & !ready.
- Reset asserted mid-read: pending response dropped, no rsp_valid after release.

## Configuration
- RAM_ARB_RR_EN defined: round-robin tie-break; winner is the master not equal to last_q.
- Not defined: fixed priority, master 0 wins every tie; last_q still maintained but unused.
- lock_q overrides both modes.

## Structure
- Package ram_arb_pkg: master-id typedef (1 bit), constants M0 = 0, M1 = 1, reset grant value.
- Sub-module ram_arb_pick: combinational winner select from valids, last_q, lock_q, with RR/fixed selection under the macro.

## Test plan
- Reset, then m0 read addr 0x010 alone -> m0_cmd_ready same cycle, m0_rsp_valid next cycle with stored word; m1_rsp_valid stays 0.
- m1 write addr 0x020 be=0b0011 data 0xAABBCCDD over 0x11223344, then m1 read 0x020 -> rdata 0x1122CCDD.
- Both valid continuously, reads, RR build -> grants alternate m0,m1,m0,m1; fixed build -> m0 every cycle, m1 ready never.
- m1 three cmds lock=1,1,0 while m0 valid -> m1 granted three consecutive cycles, m0 granted fourth.
- m1 lock=1 then m1_cmd_valid drops -> lock_q clears, m0 granted next cycle.
- m0 read accepted, reset_n pulsed low before next edge -> no m0_rsp_valid, ram_wren_a 0, first tie after release goes to m0.
